regfile_write_scheduler: RTL
============================

Name: regfile_write_scheduler

Overview:
Owns the single write port of the physical register bank and shares it between NUM_WB_PORTS writeback requesters using round-robin arbitration. After reset, and on request, it sweeps every entry to zero, because the bank itself has no reset. Output writes are registered and drive the bank's write address, data and commit inputs directly.

Parameters:
NUM_WB_PORTS, 3, number of writeback requesters (2..8)
DATA_WIDTH, 32, register data width
DEPTH, 64, number of bank entries (power of two); ADDR_W = $clog2(DEPTH)
ALLOW_WRITE_P0, 0, 1 = writes to address 0 are committed; 0 = they are acked and dropped

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = in reset)
wb_valid  input  [NUM_WB_PORTS]  requester i holds a write
wb_addr  input  [NUM_WB_PORTS] x ADDR_W  destination address per requester
wb_data  input  [NUM_WB_PORTS] x DATA_WIDTH  write data per requester
wb_ack  output  [NUM_WB_PORTS]  one-hot or zero; request i is consumed this cycle
clear_req  input  1  single-cycle pulse; re-zero the whole bank
init_done  output  1  1 = bank swept and scheduler accepting writes
rf_commit  output  1  to bank commit
rf_write_addr  output  ADDR_W  to bank write_addr
rf_new_data  output  DATA_WIDTH  to bank new_data

Behaviour:
- Reset values (rst=0, asynchronous): state=INIT, sweep counter=0, rr pointer=0, rf_commit=0, rf_write_addr=0, rf_new_data=0, init_done=0. wb_ack is combinational and is 0 while not in RUN.
- States: INIT, RUN, CLEAR. INIT and CLEAR behave identically, including the sweep.
- Sweep: each cycle, register rf_commit=1, rf_write_addr=counter and rf_new_data=0, then increment the counter. When counter==DEPTH-1 is issued, go to RUN and set init_done=1 the next cycle. A sweep takes exactly DEPTH cycles.
- Address 0 is written during the sweep regardless of ALLOW_WRITE_P0.
- RUN to CLEAR: clear_req=1 in RUN. The counter resets to 0 and init_done falls the next cycle. No ack is given in the cycle clear_req is sampled.
- clear_req is ignored in INIT and CLEAR.
- Arbitration (RUN only):
  - Combinational search over wb_valid, starting at index rr and wrapping modulo NUM_WB_PORTS; the first valid index g gets wb_ack[g]=1.
  - After a grant, rr <= (g+1) mod NUM_WB_PORTS. With no valid request, rr holds.
- Handshake: a requester holds valid, addr and data stable until acked, and may drop valid the cycle after ack. One grant per cycle, at most.
- Latency: ack in cycle t gives rf_commit=1 with the granted addr/data in cycle t+1 (registered). With no grant, rf_commit=0 next cycle; addr/data hold their previous values.
- Address 0 with ALLOW_WRITE_P0=0: acked normally, rf_commit=0, rr advances.
- Reset mid-sweep or mid-RUN: returns to INIT immediately and the sweep restarts at 0. In-flight requests are not acked and the requester retries.
- Writes acked in RUN always precede any CLEAR sweep writes on the bank port.

Test Plan:
- Reset release, no requests: rf_commit=1 for 64 consecutive cycles with addr 0..63 and data 0; init_done=1 from cycle 65; wb_ack stays 0 throughout.
- RUN, all three valid and held, rr=0: acks in order 0,1,2,0; rf_write_addr/rf_new_data follow one cycle later (addr 5/0xA, 6/0xB, 7/0xC, 5/0xA).
- RUN, only port 2 valid (addr 9, data 0xDEADBEEF) for 3 cycles: ack on port 2 each cycle; bank writes addr 9 three times; rr remains 0 after each grant.
- Port 1 writes addr 0 with data 0x55, ALLOW_WRITE_P0=0: wb_ack[1]=1, next cycle rf_commit=0; same with ALLOW_WRITE_P0=1 gives rf_commit=1, addr 0, data 0x55.
- clear_req pulse in RUN with port 0 valid: no ack that cycle; init_done=0 next cycle; 64-cycle zero sweep; port 0 acked on the first RUN cycle after the sweep.
- rst asserted at sweep counter 30: outputs reset asynchronously; after release the sweep restarts at addr 0 and completes 64 writes.

Source files
------------

// File: rtl/regfile_write_scheduler.sv
// Round-robin owner of the register bank write port.
// Sweeps the bank to zero after reset and on clear_req.
module regfile_write_scheduler #(
  parameter int NUM_WB_PORTS   = 3,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 64,
  parameter int ALLOW_WRITE_P0 = 0,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_WB_PORTS-1:0]        wb_valid,
  input  logic [NUM_WB_PORTS*ADDR_W-1:0] wb_addr,
  input  logic [NUM_WB_PORTS*DATA_WIDTH-1:0] wb_data,
  output logic [NUM_WB_PORTS-1:0]        wb_ack,
  input  logic                           clear_req,
  output logic                           init_done,
  output logic                           rf_commit,
  output logic [ADDR_W-1:0]              rf_write_addr,
  output logic [DATA_WIDTH-1:0]          rf_new_data
);

  localparam int PW = $clog2(NUM_WB_PORTS);

  typedef enum logic [1:0] {
    INIT,
    RUN,
    CLEAR
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   cnt;
  logic [PW-1:0]       rr;
  logic [PW-1:0]       gidx;
  logic [PW-1:0]       pidx;
  logic [PW-1:0]       rr_next;
  logic                found;
  logic                do_grant;
  logic                keep;
  logic [ADDR_W-1:0]   g_addr;
  logic [DATA_WIDTH-1:0] g_data;
  int                  k;

  // First valid requester at or after rr, wrapping.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    pidx  = '0;
    k     = 0;
    for (int i = 0; i < NUM_WB_PORTS; i++) begin
      k = int'(rr) + i;
      if (k >= NUM_WB_PORTS) k = k - NUM_WB_PORTS;
      pidx = PW'(k);
      if (!found && wb_valid[pidx]) begin
        found = 1'b1;
        gidx  = pidx;
      end
    end
  end

  always_comb begin
    do_grant = (state == RUN) && !clear_req && found;
    wb_ack   = '0;
    if (do_grant) wb_ack[gidx] = 1'b1;
    g_addr  = wb_addr[int'(gidx)*ADDR_W +: ADDR_W];
    g_data  = wb_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
    rr_next = (gidx == PW'(NUM_WB_PORTS-1)) ? '0 : gidx + 1'b1;
    keep    = (ALLOW_WRITE_P0 != 0) || (g_addr != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= INIT;
      cnt           <= '0;
      rr            <= '0;
      rf_commit     <= 1'b0;
      rf_write_addr <= '0;
      rf_new_data   <= '0;
      init_done     <= 1'b0;
    end else begin
      case (state)
        INIT, CLEAR: begin
          rf_commit     <= 1'b1;
          rf_write_addr <= cnt;
          rf_new_data   <= '0;
          cnt           <= cnt + 1'b1;
          init_done     <= 1'b0;
          if (cnt == ADDR_W'(DEPTH-1)) state <= RUN;
        end
        RUN: begin
          if (clear_req) begin
            state     <= CLEAR;
            cnt       <= '0;
            init_done <= 1'b0;
            rf_commit <= 1'b0;
          end else begin
            init_done <= 1'b1;
            rf_commit <= do_grant && keep;
            if (do_grant) begin
              rf_write_addr <= g_addr;
              rf_new_data   <= g_data;
              rr            <= rr_next;
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule
